// File: rtl/syn_acortex_lb_master.sv
// ACORTEX Local Bus master: turns single host register transactions into LB cycles,
// with block-select decode, slave timeout and a saturating error counter.
module syn_acortex_lb_master #(
   parameter int LB_ADDR_W      = 8,
   parameter int LB_DATA_W      = 32,
   parameter int BLK_SEL_W      = 4,
   parameter int TIMEOUT_CYCLES = 64,
   parameter int ERR_CNT_W      = 8
) (
   input  logic                           clk_ir,
   input  logic                           rst_il,
   input  logic                           host_req_valid,
   output logic                           host_req_ready,
   input  logic                           host_req_wr,
   input  logic [BLK_SEL_W+LB_ADDR_W-1:0] host_req_addr,
   input  logic [LB_DATA_W-1:0]           host_req_data,
   output logic                           host_rsp_valid,
   output logic [LB_DATA_W-1:0]           host_rsp_data,
   output logic                           host_rsp_err,
   output logic [ERR_CNT_W-1:0]           err_cnt,
   output logic                           i2cm_wr_en,
   output logic                           i2cm_rd_en,
   output logic                           cmux_wr_en,
   output logic                           cmux_rd_en,
   output logic                           wmdrvr_wr_en,
   output logic                           wmdrvr_rd_en,
   output logic                           acache_wr_en,
   output logic                           acache_rd_en,
   output logic [LB_ADDR_W-1:0]           lbm_addr,
   output logic [LB_DATA_W-1:0]           lbm_wr_data,
   input  logic                           lbm_wr_valid,
   input  logic                           lbm_rd_valid,
   input  logic [LB_DATA_W-1:0]           lbm_rd_data
);

   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t                 r_state;
   state_t                 w_state_next;
   logic                   r_ready;
   logic                   r_wr;
   logic [1:0]             r_sel;
   logic [TMO_W-1:0]       r_tmo_cnt;
   logic [LB_ADDR_W-1:0]   r_lbm_addr;
   logic [LB_DATA_W-1:0]   r_lbm_wr_data;
   logic [LB_DATA_W-1:0]   r_rsp_data;
   logic                   r_rsp_err;
   logic [ERR_CNT_W-1:0]   r_err_cnt;

   logic                   w_accept;
   logic [BLK_SEL_W-1:0]   w_blk;
   logic                   w_sel_ok;
   logic                   w_match;
   logic                   w_tmo_last;
   logic                   w_done_ok;
   logic                   w_done_err;
   logic [3:0]             w_wr_en;
   logic [3:0]             w_rd_en;
   logic                   w_rsp_valid;

   assign w_accept   = host_req_valid & r_ready;
   assign w_blk      = host_req_addr[BLK_SEL_W+LB_ADDR_W-1:LB_ADDR_W];
   assign w_sel_ok   = (w_blk <= BLK_SEL_W'(3));
   assign w_match    = r_wr ? lbm_wr_valid : lbm_rd_valid;
   assign w_tmo_last = (r_tmo_cnt >= TMO_W'(TIMEOUT_CYCLES - 1));

   // State register
   always_ff @(posedge clk_ir or negedge rst_il) begin
      if (!rst_il) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic; w_done_* mark the cycle that commits the response
   always_comb begin
      w_state_next = r_state;
      w_done_ok    = 1'b0;
      w_done_err   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (w_sel_ok) begin
                  w_state_next = S_ISSUE;
               end else begin
                  w_state_next = S_RESP;
                  w_done_err   = 1'b1;
               end
            end
         end
         S_ISSUE: begin
            if (w_match) begin
               w_state_next = S_RESP;
               w_done_ok    = 1'b1;
            end else if (TIMEOUT_CYCLES <= 1) begin
               w_state_next = S_RESP;
               w_done_err   = 1'b1;
            end else begin
               w_state_next = S_WAIT;
            end
         end
         S_WAIT: begin
            if (w_match) begin
               w_state_next = S_RESP;
               w_done_ok    = 1'b1;
            end else if (w_tmo_last) begin
               w_state_next = S_RESP;
               w_done_err   = 1'b1;
            end
         end
         S_RESP: begin
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // Output decode: one enable for the latched slave/direction during ISSUE only
   always_comb begin
      w_wr_en     = '0;
      w_rd_en     = '0;
      w_rsp_valid = (r_state == S_RESP);
      for (int i = 0; i < 4; i++) begin
         if ((r_state == S_ISSUE) && (r_sel == 2'(i))) begin
            w_wr_en[i] = r_wr;
            w_rd_en[i] = ~r_wr;
         end
      end
   end

   // Request latch, timeout counter and response capture
   always_ff @(posedge clk_ir or negedge rst_il) begin
      if (!rst_il) begin
         r_ready       <= 1'b0;
         r_wr          <= 1'b0;
         r_sel         <= '0;
         r_tmo_cnt     <= '0;
         r_lbm_addr    <= '0;
         r_lbm_wr_data <= '0;
         r_rsp_data    <= '0;
         r_rsp_err     <= 1'b0;
         r_err_cnt     <= '0;
      end else begin
         r_ready <= (w_state_next == S_IDLE);
         if (w_accept) begin
            r_lbm_addr    <= host_req_addr[LB_ADDR_W-1:0];
            r_lbm_wr_data <= host_req_data;
            r_wr          <= host_req_wr;
            r_sel         <= w_blk[1:0];
         end
         // The enable cycle counts as the first timeout cycle
         if (r_state == S_ISSUE) begin
            r_tmo_cnt <= TMO_W'(1);
         end else if (r_state == S_WAIT) begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
         end
         if (w_done_ok) begin
            r_rsp_data <= r_wr ? '0 : lbm_rd_data;
            r_rsp_err  <= 1'b0;
         end else if (w_done_err) begin
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b1;
            if (r_err_cnt != {ERR_CNT_W{1'b1}}) begin
               r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
            end
         end
      end
   end

   assign host_req_ready = r_ready;
   assign host_rsp_valid = w_rsp_valid;
   assign host_rsp_data  = r_rsp_data;
   assign host_rsp_err   = r_rsp_err;
   assign err_cnt        = r_err_cnt;
   assign lbm_addr       = r_lbm_addr;
   assign lbm_wr_data    = r_lbm_wr_data;

   assign i2cm_wr_en     = w_wr_en[0];
   assign i2cm_rd_en     = w_rd_en[0];
   assign cmux_wr_en     = w_wr_en[1];
   assign cmux_rd_en     = w_rd_en[1];
   assign wmdrvr_wr_en   = w_wr_en[2];
   assign wmdrvr_rd_en   = w_rd_en[2];
   assign acache_wr_en   = w_wr_en[3];
   assign acache_rd_en   = w_rd_en[3];

endmodule

// File: tb/tb_syn_acortex_lb_master.sv
// Directed bench for syn_acortex_lb_master: scoreboard of expected responses
// (due cycle, err, data) checked by a response monitor with immediate assertions.
module tb_syn_acortex_lb_master;

   logic        clk_ir;
   logic        rst_il;
   logic        host_req_valid;
   logic        host_req_ready;
   logic        host_req_wr;
   logic [11:0] host_req_addr;
   logic [31:0] host_req_data;
   logic        host_rsp_valid;
   logic [31:0] host_rsp_data;
   logic        host_rsp_err;
   logic [7:0]  err_cnt;
   logic        i2cm_wr_en, i2cm_rd_en, cmux_wr_en, cmux_rd_en;
   logic        wmdrvr_wr_en, wmdrvr_rd_en, acache_wr_en, acache_rd_en;
   logic [7:0]  lbm_addr;
   logic [31:0] lbm_wr_data;
   logic        lbm_wr_valid;
   logic        lbm_rd_valid;
   logic [31:0] lbm_rd_data;

   syn_acortex_lb_master #(
      .LB_ADDR_W(8), .LB_DATA_W(32), .BLK_SEL_W(4), .TIMEOUT_CYCLES(64), .ERR_CNT_W(8)
   ) dut (
      .clk_ir(clk_ir), .rst_il(rst_il),
      .host_req_valid(host_req_valid), .host_req_ready(host_req_ready),
      .host_req_wr(host_req_wr), .host_req_addr(host_req_addr), .host_req_data(host_req_data),
      .host_rsp_valid(host_rsp_valid), .host_rsp_data(host_rsp_data), .host_rsp_err(host_rsp_err),
      .err_cnt(err_cnt),
      .i2cm_wr_en(i2cm_wr_en), .i2cm_rd_en(i2cm_rd_en),
      .cmux_wr_en(cmux_wr_en), .cmux_rd_en(cmux_rd_en),
      .wmdrvr_wr_en(wmdrvr_wr_en), .wmdrvr_rd_en(wmdrvr_rd_en),
      .acache_wr_en(acache_wr_en), .acache_rd_en(acache_rd_en),
      .lbm_addr(lbm_addr), .lbm_wr_data(lbm_wr_data),
      .lbm_wr_valid(lbm_wr_valid), .lbm_rd_valid(lbm_rd_valid), .lbm_rd_data(lbm_rd_data)
   );

   typedef struct {
      int          due;
      logic        err;
      logic [31:0] data;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   int   rsp_cnt  = 0;
   int   en_cnt[8];
   int   en_base[8];
   logic [7:0] w_en;

   // Slave model controls
   logic sl_en    = 1'b0;
   int   sl_delay = 0;
   logic sl_stray = 1'b0;
   logic stray_rd = 1'b0;
   logic pend     = 1'b0;
   logic pend_wr  = 1'b0;
   int   el       = 0;

   // index = sel*2 + (read ? 1 : 0)
   assign w_en = {acache_rd_en, acache_wr_en, wmdrvr_rd_en, wmdrvr_wr_en,
                  cmux_rd_en, cmux_wr_en, i2cm_rd_en, i2cm_wr_en};

   initial clk_ir = 1'b0;
   always #5 clk_ir = ~clk_ir;
   always @(posedge clk_ir) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Response monitor and enable counter
   always @(negedge clk_ir) begin
      for (int i = 0; i < 8; i++) begin
         if (w_en[i]) en_cnt[i] = en_cnt[i] + 1;
      end
      if (rst_il && host_rsp_valid) begin
         rsp_cnt = rsp_cnt + 1;
         if (sb.size() == 0) begin
            chk("rsp_unexpected", 32'(sb.size()), 32'd1);
         end else begin
            mon_e = sb.pop_front();
            chk("rsp_cycle", 32'(cyc), 32'(mon_e.due));
            chk("rsp_err", {31'd0, host_rsp_err}, {31'd0, mon_e.err});
            chk("rsp_data", host_rsp_data, mon_e.data);
         end
      end
   end

   // Slave model: matching valid sl_delay cycles after the enable (0 = same cycle)
   always @(negedge clk_ir) begin
      logic w, r;
      w = 1'b0;
      r = 1'b0;
      if ((|w_en) && sl_en) begin
         pend    = 1'b1;
         el      = 0;
         pend_wr = |(w_en & 8'h55);
      end
      if (pend) begin
         if (sl_stray && el == 1) begin
            if (pend_wr) r = 1'b1; else w = 1'b1;
         end
         if (el == sl_delay) begin
            if (pend_wr) w = 1'b1; else r = 1'b1;
            pend = 1'b0;
         end
         el = el + 1;
      end
      lbm_wr_valid = w;
      lbm_rd_valid = r | stray_rd;
   end

   task automatic send(input logic wr, input logic [11:0] addr, input logic [31:0] data,
                       input int lat, input logic eerr, input logic [31:0] edata);
      exp_t e;
      int   n;
      for (int i = 0; i < 8; i++) en_base[i] = en_cnt[i];
      @(negedge clk_ir);
      host_req_valid = 1'b1;
      host_req_wr    = wr;
      host_req_addr  = addr;
      host_req_data  = data;
      n = 0;
      while (!host_req_ready && n < 50) begin
         @(negedge clk_ir);
         n++;
      end
      if (n >= 50) chk("accept_timeout", 32'(n), 32'd0);
      e.due  = cyc + lat;
      e.err  = eerr;
      e.data = edata;
      sb.push_back(e);
      @(posedge clk_ir);
      #1 host_req_valid = 1'b0;
      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clk_ir);
         n++;
      end
      if (sb.size() != 0) begin
         chk("rsp_missing", 32'(sb.size()), 32'd0);
         sb.delete();
      end
      @(negedge clk_ir);
   endtask

   task automatic chk_en(input string tag, input int idx);
      for (int i = 0; i < 8; i++) begin
         chk(tag, 32'(en_cnt[i] - en_base[i]), (i == idx) ? 32'd1 : 32'd0);
      end
   endtask

   initial begin
      int rsp_base;
      for (int i = 0; i < 8; i++) begin
         en_cnt[i]  = 0;
         en_base[i] = 0;
      end
      rst_il         = 1'b0;
      host_req_valid = 1'b0;
      host_req_wr    = 1'b0;
      host_req_addr  = '0;
      host_req_data  = '0;
      lbm_rd_data    = '0;
      repeat (3) @(negedge clk_ir);
      chk("rst_ready", {31'd0, host_req_ready}, 32'd0);
      chk("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
      chk("rst_rsp_valid", {31'd0, host_rsp_valid}, 32'd0);
      chk("rst_rsp_data", host_rsp_data, 32'd0);
      chk("rst_lbm_addr", {24'd0, lbm_addr}, 32'd0);
      chk("rst_lbm_wr_data", lbm_wr_data, 32'd0);
      chk("rst_enables", {24'd0, w_en}, 32'd0);
      rst_il = 1'b1;
      #1 chk("ready_after_release", {31'd0, host_req_ready}, 32'd0);
      @(negedge clk_ir);
      chk("ready_rise", {31'd0, host_req_ready}, 32'd1);

      // cmux write, slave completes 2 cycles after the enable: rsp at E+3 = T+4
      sl_en = 1'b1; sl_delay = 2;
      send(1'b1, 12'h105, 32'h0000_1234, 4, 1'b0, 32'h0);
      chk("wr_lbm_addr", {24'd0, lbm_addr}, 32'h05);
      chk("wr_lbm_wr_data", lbm_wr_data, 32'h0000_1234);
      chk_en("wr_cmux_en", 2);

      // acache read, combinational slave: rsp at E+1 = T+2
      sl_delay = 0; lbm_rd_data = 32'hCAFE_F00D;
      send(1'b0, 12'h310, 32'hDEAD_0001, 2, 1'b0, 32'hCAFE_F00D);
      chk("rd_lbm_addr", {24'd0, lbm_addr}, 32'h10);
      chk("rd_lbm_wr_data_hold", lbm_wr_data, 32'hDEAD_0001);
      chk_en("rd_acache_en", 7);

      // wmdrvr read with no slave: timeout rsp at E+64 = T+65
      sl_en = 1'b0;
      send(1'b0, 12'h203, 32'h0, 65, 1'b1, 32'h0);
      chk("tmo_err_cnt", {24'd0, err_cnt}, 32'd1);
      chk_en("tmo_wm_en", 5);

      // bad select: no enable, rsp at T+1
      send(1'b1, 12'h7AA, 32'h55, 1, 1'b1, 32'h0);
      chk("bad_err_cnt", {24'd0, err_cnt}, 32'd2);
      chk("bad_lbm_addr", {24'd0, lbm_addr}, 32'hAA);
      chk_en("bad_no_en", -1);

      // 253 more errors reach 255 exactly, further errors saturate
      for (int i = 0; i < 253; i++) send(1'b0, 12'hF00 | 12'(i), 32'h0, 1, 1'b1, 32'h0);
      chk("err_cnt_at_max", {24'd0, err_cnt}, 32'hFF);
      for (int i = 0; i < 46; i++) send(1'b1, 12'h800 | 12'(i), 32'h0, 1, 1'b1, 32'h0);
      chk("err_cnt_saturated", {24'd0, err_cnt}, 32'hFF);

      // read with a stray wr_valid first; rd_valid at E+4 -> rsp at E+5 = T+6
      sl_en = 1'b1; sl_delay = 4; sl_stray = 1'b1; lbm_rd_data = 32'h1234_5678;
      send(1'b0, 12'h008, 32'h0, 6, 1'b0, 32'h1234_5678);
      chk_en("stray_i2cm_en", 1);
      sl_stray = 1'b0;

      // stray rd_valid in IDLE: no response, no count
      sl_en = 1'b0;
      rsp_base = rsp_cnt;
      @(negedge clk_ir); stray_rd = 1'b1;
      @(negedge clk_ir); stray_rd = 1'b0;
      repeat (3) @(negedge clk_ir);
      chk("idle_stray_no_rsp", 32'(rsp_cnt), 32'(rsp_base));
      chk("idle_stray_err_cnt", {24'd0, err_cnt}, 32'hFF);

      // reset during WAIT aborts the transaction
      @(negedge clk_ir);
      host_req_valid = 1'b1; host_req_wr = 1'b0; host_req_addr = 12'h203;
      @(posedge clk_ir);
      #1 host_req_valid = 1'b0;
      repeat (5) @(negedge clk_ir);
      rst_il = 1'b0;
      #1;
      chk("midrst_enables", {24'd0, w_en}, 32'd0);
      chk("midrst_ready", {31'd0, host_req_ready}, 32'd0);
      chk("midrst_err_cnt", {24'd0, err_cnt}, 32'd0);
      @(negedge clk_ir);
      rst_il = 1'b1;
      #1 chk("midrst_ready_release", {31'd0, host_req_ready}, 32'd0);
      @(negedge clk_ir);
      chk("midrst_ready_rise", {31'd0, host_req_ready}, 32'd1);
      repeat (70) @(negedge clk_ir);
      chk("midrst_no_rsp", 32'(rsp_cnt), 32'(rsp_base));

      // normal acache write after reset, slave 1 cycle late: rsp at T+3
      sl_en = 1'b1; sl_delay = 1;
      send(1'b1, 12'h3FF, 32'hA5A5_A5A5, 3, 1'b0, 32'h0);
      chk("post_rst_lbm_addr", {24'd0, lbm_addr}, 32'hFF);
      chk("post_rst_err_cnt", {24'd0, err_cnt}, 32'd0);
      chk_en("post_rst_acache_en", 6);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
